pwm_bank_16ch: RTL and testbench
================================

Name: pwm_bank_16ch

Overview:
- Downstream consumer of the SPI register file. Takes the four 8-bit enable registers and the 8-bit duty-cycle register written over SPI.
- Drives 16 output pins, each either static-off, static-on or PWM.
- One shared free-running 8-bit PWM timebase with a clock prescaler gives a ~3 kHz PWM frequency from the 10 MHz system clock.
- The duty value is shadowed at period boundaries, so SPI writes never produce runt pulses.

Parameters:
- CLK_DIV, 13: system clocks per PWM count step. Legal range 1..255. PWM period = 256*CLK_DIV clocks.
- DIV_W, 8: prescaler counter width. Must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_reg_out_7_0  input  8  output enable, channels 7..0.
- en_reg_out_15_8  input  8  output enable, channels 15..8.
- en_reg_pwm_7_0  input  8  PWM-mode enable, channels 7..0.
- en_reg_pwm_15_8  input  8  PWM-mode enable, channels 15..8.
- pwm_duty_cycle  input  8  requested duty; 0x00 = 0%, 0xFF = 100%.
- out  output  16  channel outputs, registered.
- period_start  output  1  one-clock pulse on the first clock of each PWM period, registered.

Behaviour:
- Reset (async assert, sync release): div_cnt=0, pwm_cnt=0, duty_active=0x00, out=16'h0000, period_start=0.
- Prescaler div_cnt counts 0..CLK_DIV-1 and wraps to 0. step = (div_cnt==CLK_DIV-1).
- When step=1: pwm_cnt increments, wrapping 255->0. pwm_cnt holds otherwise.
- Period boundary: wrap = step & (pwm_cnt==255).
  - On wrap: duty_active <= pwm_duty_cycle, and period_start <= 1 for the next clock only.
  - pwm_duty_cycle changes in mid-period are ignored until the next wrap. A value written during the last clock before wrap is the one captured.
- Compare: pwm_high = (duty_active==8'hFF) | (pwm_cnt < duty_active), evaluated on the current-cycle counter values.
  - 0x00: never high.
  - 0xFF: always high (no one-step low gap).
  - Otherwise high for duty*CLK_DIV clocks per period.
- Channel i: en_out = {en_reg_out_15_8, en_reg_out_7_0}[i]; en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}[i].
  - next out[i] = en_out ? (en_pwm ? pwm_high : 1) : 0.
  - out is registered: 1-clock latency from any enable change.
  - Enables are not shadowed and take effect immediately, even mid-period.
- All PWM-mode channels share the same phase: rising edges are aligned, at period start.
- First period after reset release: duty_active=0, so PWM channels stay low. The live duty is captured at the first wrap, 256*CLK_DIV clocks after release.
- CLK_DIV=1: step is constant 1; period = 256 clocks.
- Reset mid-period: the same async clear applies; counters restart from 0 and the shadow duty returns to 0.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, all enables 0, duty=0x80, run 2 periods (6656 clocks, CLK_DIV=13) -> out==0x0000 throughout; period_start pulses at clocks 3328 and 6656 after release.
2. en_reg_out_7_0=0x01, en_reg_pwm_7_0=0x00 -> out[0]=1 one clock later; other bits stay 0. Clear en_reg_out_7_0 -> out[0]=0 one clock later.
3. en_out=en_pwm=0xFF/0xFF, duty=0x80, after the first wrap -> each channel high exactly 1664 clocks and low 1664 per period; all 16 edges coincident; rising edge 1 clock after period_start.
4. duty=0x00, then 0xFF, each held for 2 full periods -> PWM channels constant 0, then constant 1 with no glitch across wraps.
5. duty=0x40 steady; change to 0xC0 at pwm_cnt=100 -> current period completes with 64*13=832 clocks high; next period has 192*13=2496 clocks high.
6. Assert rst for 3 clocks mid-period with channels active -> out=0 and period_start=0 asynchronously during reset; after release, PWM output stays low for 3328 clocks, then follows duty.

Source files
------------

// File: rtl/pwm_bank_16ch.sv
// ---------------------------------------------------------------------------
// pwm_bank_16ch
//
// Sixteen-channel output bank driven from the SPI register file. Each channel
// is static-off, static-on or PWM. All PWM channels share one free-running
// 8-bit timebase, so their rising edges are aligned at the start of each
// period. The requested duty is shadowed at the period boundary, so an SPI
// write in mid-period never produces a runt pulse.
//
// Parameters:
//   CLK_DIV  system clocks per PWM count step (legal 1..255);
//            PWM period = 256*CLK_DIV clocks
//   DIV_W    prescaler counter width, 2**DIV_W >= CLK_DIV
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset, released synchronously
//   en_reg_out_7_0   output enable, channels 7..0
//   en_reg_out_15_8  output enable, channels 15..8
//   en_reg_pwm_7_0   PWM-mode enable, channels 7..0
//   en_reg_pwm_15_8  PWM-mode enable, channels 15..8
//   pwm_duty_cycle   requested duty, 0x00 = 0%, 0xFF = 100%
//   out              registered channel outputs
//   period_start     registered one-clock pulse on the first clock of a period
// ---------------------------------------------------------------------------
module pwm_bank_16ch #(
    parameter int CLK_DIV = 13,
    parameter int DIV_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    // Terminal count of the prescaler. With CLK_DIV=1 this is 0, the
    // prescaler never leaves 0 and every clock is a count step.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [7:0]       pwm_cnt_r;
    logic [7:0]       duty_active_r;
    logic [15:0]      out_r;
    logic             period_start_r;

    logic             step_s;
    logic             wrap_s;
    logic             pwm_high_s;
    logic [15:0]      en_out_s;
    logic [15:0]      en_pwm_s;
    logic [15:0]      out_next_s;

    // Timebase decode and shared PWM compare on the current counter values.
    always_comb begin
        step_s = (div_cnt_r == DIV_LAST);
        wrap_s = step_s && (pwm_cnt_r == 8'hFF);
        // 0xFF is forced high so full duty has no one-step low gap at count 255.
        if (duty_active_r == 8'hFF) begin
            pwm_high_s = 1'b1;
        end else if (pwm_cnt_r < duty_active_r) begin
            pwm_high_s = 1'b1;
        end else begin
            pwm_high_s = 1'b0;
        end
    end

    // Per-channel output select; enables are used live, not shadowed.
    always_comb begin
        en_out_s   = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm_s   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        out_next_s = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (!en_out_s[i]) begin
                out_next_s[i] = 1'b0;
            end else if (en_pwm_s[i]) begin
                out_next_s[i] = pwm_high_s;
            end else begin
                out_next_s[i] = 1'b1;
            end
        end
    end

    // Prescaler: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (step_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // PWM counter: advances once per prescaler step, wraps 255 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= 8'h00;
        end else if (step_s) begin
            pwm_cnt_r <= pwm_cnt_r + 8'h01;
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Duty shadow: the live duty is only sampled at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_active_r <= 8'h00;
        end else if (wrap_s) begin
            duty_active_r <= pwm_duty_cycle;
        end else begin
            duty_active_r <= duty_active_r;
        end
    end

    // Output registers: channel pins and the period-start strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r          <= 16'h0000;
            period_start_r <= 1'b0;
        end else begin
            out_r          <= out_next_s;
            period_start_r <= wrap_s;
        end
    end

    assign out          = out_r;
    assign period_start = period_start_r;

endmodule

// File: tb/tb_pwm_bank_16ch.sv
// ---------------------------------------------------------------------------
// tb_pwm_bank_16ch
//
// Directed bench for pwm_bank_16ch with the default CLK_DIV=13 (period 3328
// clocks). Static enable combinations come from a vector table; the period
// timing, duty shadowing and reset corner cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_pwm_bank_16ch;

    localparam int PERIOD = 3328;

    logic        clk;
    logic        rst;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    int n_vec  = 0;
    int n_fail = 0;

    pwm_bank_16ch dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [15:0] exp_lo;   // expected out while the PWM level is low
        logic [15:0] exp_hi;   // expected out while the PWM level is high
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
    endtask

    task automatic wait_ps(input string nm);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 4000);
        check(nm, {31'd0, period_start}, 32'd1);
    endtask

    // Called right after a period_start sample with all channels in PWM mode.
    // Runs one full period; optionally changes the live duty after tick chg_tick.
    task automatic measure(input string nm, input int exp_hi, input logic [15:0] exp_first,
                           input int chg_tick, input logic [7:0] chg_duty);
        int          hi;
        int          gl;
        int          psn;
        logic [15:0] first;
        hi    = 0;
        gl    = 0;
        psn   = 0;
        first = 16'h0000;
        for (int k = 1; k <= PERIOD; k++) begin
            tick();
            if (k == 1) first = out;
            if (out == 16'hFFFF) hi++;
            else if (out != 16'h0000) gl++;
            if (period_start) psn++;
            if (k == chg_tick) pwm_duty_cycle = chg_duty;
        end
        check({nm, "_high_clks"}, hi, exp_hi);
        check({nm, "_split_edges"}, gl, 32'd0);
        check({nm, "_first_out"}, {16'd0, first}, {16'd0, exp_first});
        check({nm, "_ps_count"}, psn, 32'd1);
        check({nm, "_ps_at_end"}, {31'd0, period_start}, 32'd1);
    endtask

    initial begin
        int          nz;
        int          psn;
        int          ps_pos [2];
        logic [15:0] prev;

        vecs[0] = '{16'h0001, 16'h0000, 16'h0001, 16'h0001};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{16'h00FF, 16'h0000, 16'h00FF, 16'h00FF};
        vecs[3] = '{16'hFF00, 16'h0F00, 16'hF000, 16'hFF00};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[5] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[6] = '{16'hA5A5, 16'h0F0F, 16'hA0A0, 16'hA5A5};
        vecs[7] = '{16'h8001, 16'h8000, 16'h0001, 16'h8001};

        // Reset, all channels disabled, duty 0x80.
        rst = 1'b1;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h80;
        repeat (3) tick();
        check("reset_out", {16'd0, out}, 32'd0);
        check("reset_ps", {31'd0, period_start}, 32'd0);
        rst = 1'b0;

        // Two full periods: out stays 0, strobes at 3328 and 6656.
        nz = 0;
        psn = 0;
        ps_pos[0] = 0;
        ps_pos[1] = 0;
        for (int n = 1; n <= 2 * PERIOD; n++) begin
            tick();
            if (out != 16'h0000) nz++;
            if (period_start) begin
                if (psn < 2) ps_pos[psn] = n;
                psn++;
            end
        end
        check("idle_out_nonzero", nz, 32'd0);
        check("idle_ps_count", psn, 32'd2);
        check("idle_ps_first", ps_pos[0], 32'd3328);
        check("idle_ps_second", ps_pos[1], 32'd6656);

        // Fresh reset: shadow duty is 0 for the whole first period.
        pwm_duty_cycle = 8'h00;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        prev = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            set_en(vecs[i].en_out, vecs[i].en_pwm);
            #1;
            check($sformatf("vecA%0d_no_comb", i), {16'd0, out}, {16'd0, prev});
            tick();
            check($sformatf("vecA%0d_out", i), {16'd0, out}, {16'd0, vecs[i].exp_lo});
            prev = vecs[i].exp_lo;
        end

        // All channels in PWM mode; first wrap captures 0x80.
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h80;
        wait_ps("p0_wait");
        check("p0_out_at_ps", {16'd0, out}, 32'd0);
        pwm_duty_cycle = 8'h00;
        measure("p1_duty80", 1664, 16'hFFFF, 0, 8'h00);
        measure("p2_duty00", 0, 16'h0000, 0, 8'h00);
        measure("p3_duty00", 0, 16'h0000, 1, 8'hFF);
        measure("p4_dutyFF", PERIOD, 16'hFFFF, 0, 8'h00);
        measure("p5_dutyFF", PERIOD, 16'hFFFF, 1, 8'h40);
        // Mid-period change at pwm_cnt=100 must not affect the current period.
        measure("p6_duty40", 832, 16'hFFFF, 1300, 8'hC0);
        // Duty written during the last clock before the wrap is captured.
        measure("p7_dutyC0", 2496, 16'hFFFF, PERIOD - 1, 8'hFF);

        // Duty 0xFF active: PWM channels read as high.
        for (int i = 0; i < 8; i++) begin
            set_en(vecs[i].en_out, vecs[i].en_pwm);
            tick();
            check($sformatf("vecB%0d_out", i), {16'd0, out}, {16'd0, vecs[i].exp_hi});
        end
        set_en(16'hFFFF, 16'hFFFF);
        repeat (20) tick();
        check("pre_rst_out", {16'd0, out}, 32'h0000FFFF);

        // Asynchronous reset mid-period, held for 3 clocks.
        pwm_duty_cycle = 8'h80;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", {16'd0, out}, 32'd0);
        check("async_rst_ps", {31'd0, period_start}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_hold%0d_out", i), {16'd0, out}, 32'd0);
        end
        rst = 1'b0;
        nz = 0;
        psn = 0;
        for (int n = 1; n < PERIOD; n++) begin
            tick();
            if (out != 16'h0000) nz++;
            if (period_start) psn++;
        end
        check("post_rst_out_nonzero", nz, 32'd0);
        check("post_rst_ps_early", psn, 32'd0);
        tick();
        check("post_rst_ps", {31'd0, period_start}, 32'd1);
        check("post_rst_out_at_ps", {16'd0, out}, 32'd0);
        measure("p_after_rst", 1664, 16'hFFFF, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
